serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand and difference width in bits (WIDTH >= 2).
REQ-002 The block SHALL have parameter DIGIT, default 1, meaning the bits processed per cycle; WIDTH % DIGIT == 0 SHALL be required, and elaboration SHALL fail otherwise.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  request a new subtraction.
REQ-006 The block SHALL have port a  input  WIDTH  minuend.
REQ-007 The block SHALL have port b  input  WIDTH  subtrahend.
REQ-008 The block SHALL have port b_in  input  1  borrow into the LSB.
REQ-009 The block SHALL have port busy  output  1  operation in progress.
REQ-010 The block SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 The block SHALL have port d  output  WIDTH  difference a - b - b_in, modulo 2^WIDTH.
REQ-012 The block SHALL have port b_out  output  1  borrow out of the MSB.
REQ-013 The block SHALL have port ovf  output  1  signed overflow; this port exists only with SERIAL_SUB_OVF_EN.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE.
REQ-015 The FSM transitions SHALL be: IDLE->RUN on start; RUN->DONE after N = WIDTH/DIGIT processing edges; DONE->IDLE without start; DONE->RUN with start.
REQ-016 start SHALL be accepted only when busy == 0, i.e. in IDLE or DONE; start in RUN SHALL be ignored with no effect on the operation or its result.
REQ-017 On an accepting edge the block SHALL capture a, b and b_in into internal registers, so later input changes have no effect on the operation.
REQ-018 Each RUN edge SHALL process one DIGIT-bit slice, LSB slice first: slice difference = a_slice - b_slice - borrow, with the borrow register carried to the next slice (full-subtractor ripple within the slice).
REQ-019 busy SHALL be high exactly N cycles, starting the cycle after the accepting edge.
REQ-020 done SHALL be high exactly one cycle, the cycle after the N-th processing edge.
REQ-021 Latency from the start edge to done SHALL be N+1 edges; back-to-back operations SHALL sustain one result per N+1 cycles.
REQ-022 d and b_out SHALL update only as a complete result when entering DONE, and SHALL hold until the next DONE; partial results SHALL never be visible.
REQ-023 b_out SHALL be 1 iff {a} < {b} + b_in as unsigned values.

Reset
REQ-024 When rst_n is low, regardless of clk, the block SHALL go to IDLE with busy = 0, done = 0, d = 0, b_out = 0, ovf = 0, and clear the internal operand, borrow and slice-counter registers.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done SHALL follow, and the first start after release SHALL behave as from power-up.
REQ-026 Deassertion of rst_n SHALL take effect on the next rising clk; start sampled on that edge SHALL be accepted.

Configuration
REQ-027 The block SHALL support the macro SERIAL_SUB_OVF_EN.
REQ-028 With SERIAL_SUB_OVF_EN defined, the block SHALL provide port ovf, registered with d, equal to (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]) for two's-complement operands.
REQ-029 Without SERIAL_SUB_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 With WIDTH=8, DIGIT=1 and a=0x05, b=0x03, b_in=0, pulsing start -> busy for 8 cycles, then done for 1 cycle with d=0x02, b_out=0.
REQ-031 With WIDTH=8, DIGIT=1 and a=0x00, b=0x01, b_in=0 -> d=0xFF, b_out=1; with a=0x00, b=0x00, b_in=1 -> d=0xFF, b_out=1.
REQ-032 With SERIAL_SUB_OVF_EN defined, a=0x80, b=0x01, b_in=0 -> d=0x7F, ovf=1, b_out=0; a=0x7F, b=0xFF -> d=0x80, ovf=1, b_out=1.
REQ-033 Pulsing start with a=0x10, b=0x01, then asserting start again with a=0xFF, b=0x00 at cycle 3 -> single done with d=0x0F; the new start asserted on the done cycle starts the second operation, with d=0xFF on its done.
REQ-034 Asserting rst_n=0 for one cycle at cycle 4 of RUN -> busy=0 and done=0 immediately, no done pulse, and a following start computes correctly.
REQ-035 With WIDTH=16, DIGIT=4 and a=0x1234, b=0x0235, b_in=1 -> busy 4 cycles, d=0x0FFE, b_out=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: d = a - b - b_in, DIGIT bits per cycle, LSB slice first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             last, accept;
  logic [DIGIT:0]   slice;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  assign accept = start && (state != RUN);
  assign last   = (cnt == '0);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Slice difference; bit DIGIT is the borrow out of the slice.
  assign slice = {1'b0, a_reg[DIGIT-1:0]} - {1'b0, b_reg[DIGIT-1:0]}
               - (DIGIT+1)'(borrow);

  generate
    if (N == 1) begin : g_single
      assign acc_nxt = slice[DIGIT-1:0];
    end else begin : g_multi
      assign acc_nxt = {slice[DIGIT-1:0], acc[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      acc    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      b_out  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_reg  <= a;
      b_reg  <= b;
      acc    <= '0;
      borrow <= b_in;
      cnt    <= CW'(N - 1);
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= a[WIDTH-1];
      b_msb  <= b[WIDTH-1];
`endif
    end else if (state == RUN) begin
      a_reg  <= a_reg >> DIGIT;
      b_reg  <= b_reg >> DIGIT;
      acc    <= acc_nxt;
      borrow <= slice[DIGIT];
      cnt    <= cnt - CW'(1);
      // Outputs change only once the full difference is assembled.
      if (last) begin
        d     <= acc_nxt;
        b_out <= slice[DIGIT];
`ifdef SERIAL_SUB_OVF_EN
        ovf   <= (a_msb != b_msb) && (acc_nxt[WIDTH-1] != a_msb);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (8-bit/1-digit and 16-bit/4-digit instances).
// ovf checks are compiled in when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, bin8, busy8, done8, bo8;
  logic [7:0]  a8, b8, d8;
  logic        start16, bin16, busy16, done16, bo16;
  logic [15:0] a16, b16, d16;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf8, ovf16;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [7:0] prev_d = 8'h00;
  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_sub8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .b_in(bin8),
    .busy(busy8), .done(done8), .d(d8), .b_out(bo8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_sub16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .b_in(bin16),
    .busy(busy16), .done(done16), .d(d16), .b_out(bo16)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf16)
`endif
  );

  // Scoreboard: every done pulse of the 8-bit instance consumes one expectation.
  always @(negedge clk) begin
    if (done8) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done d=%h b_out=%b (no result expected)", d8, bo8);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (d8 !== e.d || bo8 !== e.bo) begin
          errors++;
          $display("FAIL result d=%h b_out=%b expected d=%h b_out=%b", d8, bo8, e.d, e.bo);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf8 !== e.ovf) begin
          errors++;
          $display("FAIL ovf got=%b expected=%b (d=%h)", ovf8, e.ovf, d8);
        end
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_b, input logic tbin,
                        input logic [7:0] ed, input logic ebo, input logic eovf);
    int busy_cnt;
    int guard;
    logic held;
    @(negedge clk);
    a8 = ta; b8 = tb_b; bin8 = tbin; start8 = 1'b1;
    q.push_back('{ed, ebo, eovf});
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    busy_cnt = 0; guard = 0; held = 1'b1;
    while (!done8 && guard < 40) begin
      if (busy8) busy_cnt++;
      if (d8 !== prev_d) held = 1'b0;
      @(negedge clk);
      guard++;
    end
    chk("done_seen", {15'd0, done8}, 16'd1);
    chk("busy_cycles", 16'(busy_cnt), 16'd8);
    chk("d_held_during_run", {15'd0, held}, 16'd1);
    @(negedge clk);
    chk("done_one_cycle", {15'd0, done8}, 16'd0);
    chk("d_holds_after_done", {8'd0, d8}, {8'd0, ed});
    prev_d = ed;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    int  cnt;
    logic saw;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};
    vecs[7] = '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; bin16 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {15'd0, busy8}, 16'd0);
    chk("reset_done", {15'd0, done8}, 16'd0);
    chk("reset_d", {8'd0, d8}, 16'd0);
    chk("reset_b_out", {15'd0, bo8}, 16'd0);
    chk("reset_d16", d16, 16'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].d, vecs[i].bo, vecs[i].ovf);

    // Start during RUN is ignored; start on the done cycle launches the next op.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    q.push_back('{8'h0F, 1'b0, 1'b0});
    t = 0;
    @(negedge clk); t++; start8 = 1'b0;
    @(negedge clk); t++;
    @(negedge clk); t++;
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk); t++; start8 = 1'b0;
    while (!done8 && t < 40) begin
      @(negedge clk); t++;
    end
    chk("ignored_start_latency", 16'(t), 16'd9);
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
    q.push_back('{8'hFF, 1'b0, 1'b0});
    @(negedge clk); start8 = 1'b0;
    chk("restart_on_done_busy", {15'd0, busy8}, 16'd1);
    cnt = 0;
    while (!done8 && cnt < 40) begin
      @(negedge clk); cnt++;
    end
    chk("restart_done_seen", {15'd0, done8}, 16'd1);
    @(negedge clk);
    prev_d = 8'hFF;

    // Reset in the middle of RUN aborts the operation.
    a8 = 8'hC3; b8 = 8'h21; bin8 = 1'b0; start8 = 1'b1;
    q.push_back('{8'hA2, 1'b0, 1'b0});
    @(negedge clk); start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {15'd0, busy8}, 16'd0);
    chk("abort_done", {15'd0, done8}, 16'd0);
    chk("abort_d", {8'd0, d8}, 16'd0);
    q.delete();
    prev_d = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) saw = 1'b1;
    end
    chk("no_done_after_abort", {15'd0, saw}, 16'd0);
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

    // 16-bit operand, 4-bit digits.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0235; bin16 = 1'b1; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h0000; bin16 = 1'b0;
    cnt = 0; t = 0;
    while (!done16 && t < 40) begin
      if (busy16) cnt++;
      @(negedge clk); t++;
    end
    chk("w16_done_seen", {15'd0, done16}, 16'd1);
    chk("w16_busy_cycles", 16'(cnt), 16'd4);
    chk("w16_d", d16, 16'h0FFE);
    chk("w16_b_out", {15'd0, bo16}, 16'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("w16_ovf", {15'd0, ovf16}, 16'd0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
